ipu: RTL and testbench

Interrupt prioritization unit sitting directly upstream of the fetch stage. Latches edge-triggered requests from up to `NUM_SRC` sources, applies a software mask, selects the highest-priority pending source and drives the single-cycle `ipu_int` pulse that redirects fetch to the handler at 16'h0005. It then tracks the handshake (`int_ack` from fetch) and the in-service period until the return-from-interrupt instruction (opcode 4'b0011) retires. Nested interrupts are not supported.

---
 rtl/ipu_pkg.sv | 19 +
 rtl/ipu_prio_enc.sv | 26 ++
 rtl/ipu.sv | 127 ++++++++++++
 tb/tb_ipu.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ipu_pkg.sv
// Shared definitions for the interrupt prioritization unit.
//   ipu_state_e      : dispatch/handshake FSM states
//   RETI_OP          : return-from-interrupt opcode (instr[15:12]), decoded upstream into int_done
//   INT_VECTOR       : handler address fetch jumps to on ipu_int
//   NUM_SRC_DEFAULT  : default number of interrupt sources
package ipu_pkg;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StReq     = 2'd1,
      StAck     = 2'd2,
      StService = 2'd3
   } ipu_state_e;

   localparam logic [3:0]  RETI_OP         = 4'b0011;
   localparam logic [15:0] INT_VECTOR      = 16'h0005;
   localparam int unsigned NUM_SRC_DEFAULT = 4;

endpackage

// File: rtl/ipu_prio_enc.sv
// Combinational lowest-index-first priority encoder.
//   req_i   : request vector, bit 0 has highest priority
//   idx_o   : index of the lowest set bit (0 when none set)
//   valid_o : any bit of req_i is set
module ipu_prio_enc #(
   parameter int unsigned NUM_SRC = 4,
   parameter int unsigned ID_W    = 3
) (
   input  logic [NUM_SRC-1:0] req_i,
   output logic [ID_W-1:0]    idx_o,
   output logic               valid_o
);

   // Scan from the top down so the lowest set index is the last assignment.
   always_comb begin
      idx_o   = '0;
      valid_o = 1'b0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            idx_o   = ID_W'(i);
            valid_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ipu.sv
// Interrupt prioritization unit in front of the fetch stage.
// Latches rising edges on irq_in, masks them, dispatches the highest-priority eligible source
// with a one-cycle ipu_int pulse, then tracks the ack and in-service period until int_done.
//   clk, rst   : clock, synchronous active-low reset
//   irq_in     : request lines; a 0->1 transition raises a request
//   mask_we    : load mask_data into the mask register (1 = source disabled)
//   hold       : fetch is redirecting; defer dispatch
//   int_ack    : fetch accepted the pulse
//   int_done   : return-from-interrupt retired in fetch
//   ipu_int    : one-cycle redirect request to fetch
//   int_id     : source being serviced, valid while int_active
//   int_active : high from REQ through SERVICE
//   pending    : raw pending register
module ipu
   import ipu_pkg::*;
#(
   parameter int unsigned NUM_SRC = NUM_SRC_DEFAULT,
   parameter int unsigned ID_W    = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] irq_in,
   input  logic               mask_we,
   input  logic [NUM_SRC-1:0] mask_data,
   input  logic               hold,
   input  logic               int_ack,
   input  logic               int_done,
   output logic               ipu_int,
   output logic [ID_W-1:0]    int_id,
   output logic               int_active,
   output logic [NUM_SRC-1:0] pending
);

   ipu_state_e         state_q;
   logic [NUM_SRC-1:0] irq_prev_q;
   logic [NUM_SRC-1:0] pending_q, pending_d;
   logic [NUM_SRC-1:0] mask_q;
   logic               ipu_int_q;
   logic               int_active_q;
   logic [ID_W-1:0]    int_id_q;

   logic [NUM_SRC-1:0] irq_edge;
   logic [NUM_SRC-1:0] eligible;
   logic [NUM_SRC-1:0] clr_bit;
   logic [ID_W-1:0]    win_id;
   logic               win_valid;
   logic               dispatch;

   assign irq_edge = irq_in & ~irq_prev_q;
   assign eligible = pending_q & ~mask_q;

   ipu_prio_enc #(
      .NUM_SRC (NUM_SRC),
      .ID_W    (ID_W)
   ) u_prio_enc (
      .req_i   (eligible),
      .idx_o   (win_id),
      .valid_o (win_valid)
   );

   // A mask write in flight blocks dispatch so the decision always sees the settled mask.
   assign dispatch = (state_q == StIdle) && win_valid && !hold && !mask_we;

   always_comb begin
      clr_bit   = dispatch ? (NUM_SRC'(1) << win_id) : '0;
      // Set after clear: a new edge on the bit being dispatched stays pending.
      pending_d = (pending_q & ~clr_bit) | irq_edge;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         irq_prev_q <= '1;
         pending_q  <= '0;
         mask_q     <= '1;
      end else begin
         irq_prev_q <= irq_in;
         pending_q  <= pending_d;
         if (mask_we) begin
            mask_q <= mask_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= StIdle;
         ipu_int_q    <= 1'b0;
         int_active_q <= 1'b0;
         int_id_q     <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (dispatch) begin
                  state_q      <= StReq;
                  ipu_int_q    <= 1'b1;
                  int_active_q <= 1'b1;
                  int_id_q     <= win_id;
               end
            end
            StReq: begin
               state_q   <= StAck;
               ipu_int_q <= 1'b0;
            end
            StAck: begin
               if (int_ack) begin
                  state_q <= StService;
               end
            end
            StService: begin
               if (int_done) begin
                  state_q      <= StIdle;
                  int_active_q <= 1'b0;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign ipu_int    = ipu_int_q;
   assign int_active = int_active_q;
   assign int_id     = int_id_q;
   assign pending    = pending_q;

endmodule

// File: tb/tb_ipu.sv
module tb_ipu;

   localparam int unsigned NUM_SRC = 4;
   localparam int unsigned ID_W    = 3;

   logic               clk = 1'b0;
   logic               rst;
   logic [NUM_SRC-1:0] irq_in;
   logic               mask_we;
   logic [NUM_SRC-1:0] mask_data;
   logic               hold;
   logic               int_ack;
   logic               int_done;
   logic               ipu_int;
   logic [ID_W-1:0]    int_id;
   logic               int_active;
   logic [NUM_SRC-1:0] pending;

   int n_tests = 0;
   int n_fail  = 0;

   ipu #(
      .NUM_SRC (NUM_SRC),
      .ID_W    (ID_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .irq_in     (irq_in),
      .mask_we    (mask_we),
      .mask_data  (mask_data),
      .hold       (hold),
      .int_ack    (int_ack),
      .int_done   (int_done),
      .ipu_int    (ipu_int),
      .int_id     (int_id),
      .int_active (int_active),
      .pending    (pending)
   );

   always #5 clk = ~clk;

   // Inputs are driven and outputs sampled 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_mask(input logic [NUM_SRC-1:0] m);
      mask_we   = 1'b1;
      mask_data = m;
      step();
      mask_we   = 1'b0;
   endtask

   // Entered in the REQ cycle; returns in the first IDLE cycle after int_done.
   task automatic serve();
      step();
      int_ack = 1'b1;
      step();
      int_ack = 1'b0;
      step();
      int_done = 1'b1;
      step();
      int_done = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; irq_in = 4'b0010; mask_we = 0; mask_data = '0;
      hold = 0; int_ack = 0; int_done = 0;
      step();
      step();
      n_tests++;
      if ({ipu_int, int_active, int_id, pending} !== 9'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got int=%b act=%b id=%0d pend=%b, want all 0",
                  ipu_int, int_active, int_id, pending);
      end
      rst = 1'b1;
      step();
      step();
      step();
      n_tests++;
      if (pending !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_line_high: pending=%b, want 0000", pending);
      end
      irq_in = '0;
      step();
   endtask

   task automatic test_basic();
      write_mask(4'b0000);
      irq_in = 4'b0100;
      step();
      irq_in = '0;
      n_tests++;
      if (pending !== 4'b0100 || ipu_int !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_pend: pending=%b int=%b, want 0100 0", pending, ipu_int);
      end
      step();
      n_tests++;
      if (ipu_int !== 1'b1 || int_id !== 3'd2 || int_active !== 1'b1 || pending !== 4'b0000) begin
         n_fail++;
         $display("FAIL basic_req: int=%b id=%0d act=%b pend=%b, want 1 2 1 0000",
                  ipu_int, int_id, int_active, pending);
      end
      step();
      int_ack = 1'b1;
      n_tests++;
      if (ipu_int !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_pulse_width: int=%b, want 0", ipu_int);
      end
      step();
      int_ack = 1'b0;
      step();
      n_tests++;
      if (int_active !== 1'b1 || ipu_int !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_service: act=%b int=%b, want 1 0", int_active, ipu_int);
      end
      int_done = 1'b1;
      step();
      int_done = 1'b0;
      n_tests++;
      if (int_active !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_done: act=%b, want 0", int_active);
      end
   endtask

   task automatic test_priority();
      irq_in = 4'b1010;
      step();
      irq_in = '0;
      n_tests++;
      if (pending !== 4'b1010) begin
         n_fail++;
         $display("FAIL prio_pend: pending=%b, want 1010", pending);
      end
      step();
      n_tests++;
      if (ipu_int !== 1'b1 || int_id !== 3'd1 || pending !== 4'b1000) begin
         n_fail++;
         $display("FAIL prio_first: int=%b id=%0d pend=%b, want 1 1 1000", ipu_int, int_id, pending);
      end
      serve();
      n_tests++;
      if (ipu_int !== 1'b0 || int_active !== 1'b0) begin
         n_fail++;
         $display("FAIL prio_gap: int=%b act=%b, want 0 0", ipu_int, int_active);
      end
      step();
      n_tests++;
      if (ipu_int !== 1'b1 || int_id !== 3'd3 || pending !== 4'b0000) begin
         n_fail++;
         $display("FAIL prio_second: int=%b id=%0d pend=%b, want 1 3 0000", ipu_int, int_id, pending);
      end
      serve();
   endtask

   task automatic test_mask();
      write_mask(4'b0001);
      irq_in = 4'b0001;
      step();
      irq_in = '0;
      n_tests++;
      if (pending !== 4'b0001) begin
         n_fail++;
         $display("FAIL mask_pend: pending=%b, want 0001", pending);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         n_tests++;
         if (ipu_int !== 1'b0 || int_active !== 1'b0) begin
            n_fail++;
            $display("FAIL mask_blocked[%0d]: int=%b act=%b, want 0 0", i, ipu_int, int_active);
         end
      end
      write_mask(4'b0000);
      n_tests++;
      if (ipu_int !== 1'b0) begin
         n_fail++;
         $display("FAIL mask_early: int=%b, want 0", ipu_int);
      end
      step();
      n_tests++;
      if (ipu_int !== 1'b1 || int_id !== 3'd0) begin
         n_fail++;
         $display("FAIL mask_release: int=%b id=%0d, want 1 0", ipu_int, int_id);
      end
      serve();
   endtask

   task automatic test_hold();
      irq_in = 4'b1000;
      step();
      irq_in = '0;
      hold   = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         n_tests++;
         if (ipu_int !== 1'b0 || pending !== 4'b1000) begin
            n_fail++;
            $display("FAIL hold_deferred[%0d]: int=%b pend=%b, want 0 1000", i, ipu_int, pending);
         end
      end
      step();
      hold = 1'b0;
      n_tests++;
      if (ipu_int !== 1'b0) begin
         n_fail++;
         $display("FAIL hold_last: int=%b, want 0", ipu_int);
      end
      step();
      n_tests++;
      if (ipu_int !== 1'b1 || int_id !== 3'd3) begin
         n_fail++;
         $display("FAIL hold_release: int=%b id=%0d, want 1 3", ipu_int, int_id);
      end
      serve();
   endtask

   task automatic test_repend();
      // Stray return while idle.
      int_done = 1'b1;
      step();
      int_done = 1'b0;
      n_tests++;
      if (ipu_int !== 1'b0 || int_active !== 1'b0 || pending !== 4'b0000) begin
         n_fail++;
         $display("FAIL stray_done_idle: int=%b act=%b pend=%b, want 0 0 0000",
                  ipu_int, int_active, pending);
      end
      irq_in = 4'b0100;
      step();
      irq_in = '0;
      step();
      n_tests++;
      if (ipu_int !== 1'b1 || int_id !== 3'd2) begin
         n_fail++;
         $display("FAIL repend_first: int=%b id=%0d, want 1 2", ipu_int, int_id);
      end
      // ACK cycle without ack but with a stray return; must stay waiting for ack.
      step();
      int_done = 1'b1;
      step();
      int_done = 1'b0;
      int_ack  = 1'b1;
      step();
      int_ack = 1'b0;
      n_tests++;
      if (int_active !== 1'b1) begin
         n_fail++;
         $display("FAIL stray_done_ack: act=%b, want 1", int_active);
      end
      irq_in = 4'b0100;
      step();
      irq_in = '0;
      n_tests++;
      if (pending !== 4'b0100 || int_active !== 1'b1 || ipu_int !== 1'b0) begin
         n_fail++;
         $display("FAIL repend_service: pend=%b act=%b int=%b, want 0100 1 0",
                  pending, int_active, ipu_int);
      end
      int_done = 1'b1;
      step();
      int_done = 1'b0;
      n_tests++;
      if (int_active !== 1'b0 || ipu_int !== 1'b0) begin
         n_fail++;
         $display("FAIL repend_return: act=%b int=%b, want 0 0", int_active, ipu_int);
      end
      step();
      n_tests++;
      if (ipu_int !== 1'b1 || int_id !== 3'd2 || pending !== 4'b0000) begin
         n_fail++;
         $display("FAIL repend_second: int=%b id=%0d pend=%b, want 1 2 0000",
                  ipu_int, int_id, pending);
      end
      serve();
   endtask

   task automatic test_reset_in_service();
      irq_in = 4'b0010;
      step();
      irq_in = '0;
      step();
      n_tests++;
      if (ipu_int !== 1'b1 || int_id !== 3'd1) begin
         n_fail++;
         $display("FAIL rst_svc_dispatch: int=%b id=%0d, want 1 1", ipu_int, int_id);
      end
      step();
      int_ack = 1'b1;
      step();
      int_ack = 1'b0;
      rst     = 1'b0;
      step();
      rst = 1'b1;
      n_tests++;
      if ({ipu_int, int_active, int_id, pending} !== 9'b0) begin
         n_fail++;
         $display("FAIL rst_svc_outputs: got int=%b act=%b id=%0d pend=%b, want all 0",
                  ipu_int, int_active, int_id, pending);
      end
      step();
      irq_in = 4'b0010;
      step();
      irq_in = '0;
      n_tests++;
      if (pending !== 4'b0010) begin
         n_fail++;
         $display("FAIL rst_svc_pend: pending=%b, want 0010", pending);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         n_tests++;
         if (ipu_int !== 1'b0 || int_active !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_svc_masked[%0d]: int=%b act=%b, want 0 0", i, ipu_int, int_active);
         end
      end
      write_mask(4'b0000);
      step();
      n_tests++;
      if (ipu_int !== 1'b1 || int_id !== 3'd1) begin
         n_fail++;
         $display("FAIL rst_svc_unmask: int=%b id=%0d, want 1 1", ipu_int, int_id);
      end
      serve();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_priority();
      test_mask();
      test_hold();
      test_repend();
      test_reset_in_service();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
